// File: rtl/q_activity_monitor.sv
// Activity monitor for a JK flip-flop Q output: edge pulses, saturating toggle count, stuck flag.
// Optional 1,0,1,1 overlapping sequence detector enabled by defining SEQ_DETECT_EN.
module q_activity_monitor #(
  parameter int CNT_W       = 8,
  parameter int STUCK_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_in,
  input  logic             clear,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] toggle_count,
  output logic             count_sat,
  output logic             stuck
`ifdef SEQ_DETECT_EN
  ,
  output logic             seq_hit
`endif
);

  localparam logic [7:0]       LIMIT   = 8'(STUCK_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             q_prev_q, q_prev_d;
  logic             valid_q, valid_d;
  logic [7:0]       run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             sat_q, sat_d;
  logic             stuck_q, stuck_d;
  logic             edge_w;

  assign edge_w = valid_q & (q_in ^ q_prev_q);

  always_comb begin
    q_prev_d = q_in;
    valid_d  = 1'b1;
    run_d    = run_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    sat_d    = 1'b0;
    stuck_d  = 1'b0;
    if (clear) begin
      valid_d = 1'b0;
      run_d   = '0;
      cnt_d   = '0;
    end else begin
      rise_d = edge_w & q_in;
      fall_d = edge_w & ~q_in;
      if (edge_w && cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
      // A fresh run starts on any edge and on the first sample after reset/clear
      if (edge_w || !valid_q)  run_d = 8'd1;
      else if (run_q < LIMIT)  run_d = run_q + 8'd1;
      stuck_d = (run_d == LIMIT);
      sat_d   = (cnt_d == '1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_prev_q <= 1'b0;
      valid_q  <= 1'b0;
      run_q    <= '0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      sat_q    <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      q_prev_q <= q_prev_d;
      valid_q  <= valid_d;
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sat_q    <= sat_d;
      stuck_q  <= stuck_d;
    end
  end

  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign toggle_count = cnt_q;
  assign count_sat    = sat_q;
  assign stuck        = stuck_q;

`ifdef SEQ_DETECT_EN
  typedef enum logic [1:0] {IDLE, S1, S10, S101} seq_state_e;

  seq_state_e state_q, state_d;
  logic       hit_q, hit_d;

  always_comb begin
    state_d = state_q;
    hit_d   = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = q_in ? S1 : IDLE;
        S1:   state_d = q_in ? S1 : S10;
        S10:  state_d = q_in ? S101 : IDLE;
        S101: begin
          state_d = q_in ? S1 : S10;
          hit_d   = q_in;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
    end
  end

  assign seq_hit = hit_q;
`endif

endmodule

// File: tb/tb_q_activity_monitor.sv
// Self-checking bench for q_activity_monitor; the reference model derives outputs
// from the list of samples taken since the last reset or clear.
module tb_q_activity_monitor;

  localparam int CNT_W = 8;
  localparam int LIMIT = 16;
  localparam int VW    = 5 + CNT_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             q_in;
  logic             clear;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] toggle_count;
  logic             count_sat;
  logic             stuck;
  logic             seq_bit;
`ifdef SEQ_DETECT_EN
  logic             seq_hit;
  assign seq_bit = seq_hit;
`else
  assign seq_bit = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  bit hist[$];

  q_activity_monitor #(.CNT_W(CNT_W), .STUCK_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .q_in         (q_in),
    .clear        (clear),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .toggle_count (toggle_count),
    .count_sat    (count_sat),
    .stuck        (stuck)
`ifdef SEQ_DETECT_EN
    ,
    .seq_hit      (seq_hit)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] observed();
    return {rise_pulse, fall_pulse, count_sat, stuck, seq_bit, toggle_count};
  endfunction

  // Expected outputs from the sample history: edge total, last transition, trailing run, last four samples.
  function automatic logic [VW-1:0] model();
    int n = hist.size();
    int edges = 0;
    int run = 0;
    logic [CNT_W-1:0] cnt;
    logic r, f, s, sq;
    for (int i = 1; i < n; i++) if (hist[i] != hist[i-1]) edges++;
    cnt = (edges > 255) ? 8'd255 : 8'(edges);
    r = (n >= 2) && hist[n-2] == 1'b0 && hist[n-1] == 1'b1;
    f = (n >= 2) && hist[n-2] == 1'b1 && hist[n-1] == 1'b0;
    if (n > 0)
      for (int i = n - 1; i >= 0 && hist[i] == hist[n-1]; i--) run++;
    s = (run >= LIMIT);
`ifdef SEQ_DETECT_EN
    sq = (n >= 4) && hist[n-4] && !hist[n-3] && hist[n-2] && hist[n-1];
`else
    sq = 1'b0;
`endif
    return {r, f, (cnt == 8'd255), s, sq, cnt};
  endfunction

  // Drive one sample, let the DUT clock it, and advance the model; checks are done by callers.
  task automatic drive(input logic q, input logic c);
    q_in  = q;
    clear = c;
    @(posedge clk);
    #1;
    if (c) hist.delete();
    else   hist.push_back(q);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; q_in = 1'b0; clear = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (observed() !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", observed());
    end
    @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
  endtask

  task automatic test_single_rise();
    drive(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    checks++;
    if (rise_pulse !== 1'b1 || fall_pulse !== 1'b0 || toggle_count !== 8'd1) begin
      errors++;
      $display("FAIL single_rise: got r=%b f=%b cnt=%0d expected r=1 f=0 cnt=1",
               rise_pulse, fall_pulse, toggle_count);
    end
    drive(1'b1, 1'b0);
    checks++;
    if (rise_pulse !== 1'b0 || toggle_count !== 8'd1) begin
      errors++;
      $display("FAIL single_rise_once: got r=%b cnt=%0d expected r=0 cnt=1", rise_pulse, toggle_count);
    end
  endtask

  task automatic test_saturation();
    drive(1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      drive(i[0], 1'b0);
      checks++;
      if (observed() !== model()) begin
        errors++;
        $display("FAIL saturation cyc %0d: got %h expected %h", i, observed(), model());
      end
    end
    checks++;
    if (toggle_count !== 8'd255 || count_sat !== 1'b1) begin
      errors++;
      $display("FAIL saturation_end: got cnt=%0d sat=%b expected 255/1", toggle_count, count_sat);
    end
  endtask

  task automatic test_stuck();
    drive(1'b0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 1'b0);
      checks++;
      if (stuck !== (i >= LIMIT) || observed() !== model()) begin
        errors++;
        $display("FAIL stuck sample %0d: got stuck=%b vec=%h expected stuck=%b vec=%h",
                 i, stuck, observed(), (i >= LIMIT), model());
      end
    end
    drive(1'b0, 1'b0);
    checks++;
    if (stuck !== 1'b0 || fall_pulse !== 1'b1) begin
      errors++;
      $display("FAIL stuck_release: got stuck=%b fall=%b expected 0/1", stuck, fall_pulse);
    end
  endtask

  task automatic test_clear_priority();
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    checks++;
    if (rise_pulse !== 1'b0 || toggle_count !== 8'd0 || observed() !== model()) begin
      errors++;
      $display("FAIL clear_priority: got r=%b cnt=%0d expected r=0 cnt=0", rise_pulse, toggle_count);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(~i[0], 1'b0);
      checks++;
      if (toggle_count !== 8'(i + 1) || rise_pulse !== ~i[0] || fall_pulse !== i[0]) begin
        errors++;
        $display("FAIL back_to_back %0d: got cnt=%0d r=%b f=%b expected cnt=%0d r=%b f=%b",
                 i, toggle_count, rise_pulse, fall_pulse, i + 1, ~i[0], i[0]);
      end
    end
  endtask

  task automatic test_sequence();
    logic [6:0] pat;
    logic [6:0] hits;
    pat  = 7'b1011011;
    hits = 7'b0001001;
    drive(1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(pat[6-i], 1'b0);
      checks++;
`ifdef SEQ_DETECT_EN
      if (seq_bit !== hits[6-i]) begin
        errors++;
        $display("FAIL sequence sample %0d: got hit=%b expected %b", i + 1, seq_bit, hits[6-i]);
      end
`else
      if (seq_bit !== 1'b0 || observed() !== model()) begin
        errors++;
        $display("FAIL sequence_nodet sample %0d: got %h expected %h", i + 1, observed(), model());
      end
`endif
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
      checks++;
      if (observed() !== model()) begin
        errors++;
        $display("FAIL random cyc %0d: got %h expected %h", i, observed(), model());
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    hist.delete();
    checks++;
    if (observed() !== '0) begin
      errors++;
      $display("FAIL mid_reset_async: got %h expected 0", observed());
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0);
    checks++;
    if (rise_pulse !== 1'b0 || observed() !== model()) begin
      errors++;
      $display("FAIL mid_reset_first_sample: got %h expected %h", observed(), model());
    end
    drive(1'b0, 1'b0);
    checks++;
    if (fall_pulse !== 1'b1 || toggle_count !== 8'd1) begin
      errors++;
      $display("FAIL mid_reset_resume: got f=%b cnt=%0d expected 1/1", fall_pulse, toggle_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_saturation();
    test_stuck();
    test_clear_priority();
    test_back_to_back();
    test_sequence();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/q_activity_monitor.md
Q_ACTIVITY_MONITOR -- requirements
Module: q_activity_monitor

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, meaning the toggle counter width in bits (legal range 2..16).
REQ-002 The block SHALL have parameter STUCK_LIMIT, default 16, meaning the number of consecutive unchanged samples that flags stuck (legal range 2..255).
REQ-003 The block SHALL have port clk  input  1  the single clock, with all state updating on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  the reset, asynchronous and active-low.
REQ-005 The block SHALL have port q_in  input  1  the Q output of the upstream JK flip-flop, synchronous to clk.
REQ-006 The block SHALL have port clear  input  1  a synchronous clear of the counters and flags.
REQ-007 The block SHALL have port rise_pulse  output  1  a one-cycle pulse on a 0->1 transition of q_in.
REQ-008 The block SHALL have port fall_pulse  output  1  a one-cycle pulse on a 1->0 transition of q_in.
REQ-009 The block SHALL have port toggle_count  output  CNT_W  the number of edges seen, saturating.
REQ-010 The block SHALL have port count_sat  output  1  which is high while toggle_count is all-ones.
REQ-011 The block SHALL have port stuck  output  1  which is high when q_in has been unchanged for at least STUCK_LIMIT samples.
REQ-012 The block SHALL have port seq_hit  output  1  a one-cycle pulse on pattern detection, present only with SEQ_DETECT_EN.

Function
REQ-013 The block SHALL sample q_in every rising clk edge into q_prev and SHALL set a valid flag after the first sample following reset or clear.
REQ-014 The block SHALL define an edge as valid=1 and q_in!=q_prev at the sampling edge; there SHALL be no edge on the first sample after reset or clear.
REQ-015 All outputs SHALL be registered, so rise_pulse or fall_pulse SHALL be high in exactly the cycle after the sampling edge that saw the transition (latency 1).
REQ-016 The block SHALL increment toggle_count by 1 on each edge, holding it at 2^CNT_W-1 with no wrap, and count_sat SHALL equal (toggle_count == all-ones).
REQ-017 Run counter behaviour:
- The run counter (8 bits) SHALL reset to 1 on an edge or on the first valid sample.
- Otherwise it SHALL increment, saturating at STUCK_LIMIT.
- stuck SHALL be set when the run counter reaches STUCK_LIMIT and SHALL clear in the same cycle that rise_pulse or fall_pulse asserts.
REQ-018 When clear=1, the block SHALL, at that edge, zero toggle_count, the run counter, valid, stuck, both pulses and seq_hit, and SHALL discard any edge present in the same cycle (clear has priority).
REQ-019 Consecutive edges on back-to-back cycles SHALL each produce a pulse and a count increment, with none lost.

Reset
REQ-020 When rst_n=0, the block SHALL immediately, without a clock, force q_prev=0, valid=0, run counter=0, toggle_count=0, count_sat=0, stuck=0, rise_pulse=0, fall_pulse=0, seq_hit=0 and the detector state to IDLE.
REQ-021 Reset deassertion SHALL take effect on the next rising clk, with the first sample there treated as in REQ-014.
REQ-022 Reset asserted mid-run SHALL abandon all counts and detector progress with no partial pulse.

Configuration
REQ-023 With macro SEQ_DETECT_EN defined, the block SHALL include an overlapping Mealy detector for the sampled q_in pattern 1,0,1,1 (oldest first).
REQ-024 The SEQ_DETECT_EN detector SHALL have states IDLE, S1, S10 and S101, with these transitions (input shown after the colon):
- IDLE: 1 goes to S1, 0 goes to IDLE.
- S1: 0 goes to S10, 1 goes to S1.
- S10: 1 goes to S101, 0 goes to IDLE.
- S101: 1 gives a hit and goes to S1, 0 goes to S10.
REQ-025 With SEQ_DETECT_EN, seq_hit SHALL be high in the cycle after the completing sample, and clear SHALL return the detector to IDLE.
REQ-026 Without SEQ_DETECT_EN, the block SHALL contain no detector logic and SHALL have no seq_hit port.

Verification
REQ-027 Bench scenario: q_in=0 for 3 cycles, then 1 -> a single rise_pulse one cycle later, toggle_count=1, fall_pulse=0.
REQ-028 Bench scenario: q_in alternating each cycle for 300 cycles with CNT_W=8 -> toggle_count=255 and count_sat=1 from the 255th edge on, with no wrap.
REQ-029 Bench scenario: q_in held 1 for 20 cycles with STUCK_LIMIT=16 -> stuck=1 after the 16th unchanged sample; the next toggle -> stuck=0 in the same cycle as fall_pulse.
REQ-030 Bench scenario: a 0->1 edge with clear=1 in the same cycle -> no rise_pulse and toggle_count=0 next cycle.
REQ-031 Bench scenario (SEQ_DETECT_EN): q_in samples 1,0,1,1,0,1,1 -> seq_hit pulses after the 4th and the 7th samples, confirming overlap.
REQ-032 Bench scenario: rst_n pulsed low between clock edges mid-sequence -> all outputs 0 immediately, and a sample of 1 after release produces no rise_pulse.
